// File: rtl/jtkiwi_objbuf_pkg.sv
// rtl/jtkiwi_objbuf_pkg.sv - pixel layout and FSM encodings for the sprite line buffer
package jtkiwi_objbuf_pkg;

  localparam int OBJ_COL_LSB = 0;
  localparam int OBJ_COL_W   = 4;
  localparam int OBJ_PAL_LSB = 4;
  localparam int OBJ_PAL_W   = 5;

  localparam logic [OBJ_COL_W-1:0] OBJ_TRANSP = 4'h0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } objbuf_state_t;

  function automatic logic is_opaque(input logic [OBJ_COL_W-1:0] col);
    return col != OBJ_TRANSP;
  endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// rtl/jtframe_dual_ram.sv - single-clock RAM with a write-only port 0 and a read/write port 1
module jtframe_dual_ram #(
  parameter int DW = 9,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic [DW-1:0] data0,
  input  logic [AW-1:0] addr0,
  input  logic          we0,
  input  logic [DW-1:0] data1,
  input  logic [AW-1:0] addr1,
  input  logic          we1,
  output logic [DW-1:0] q1
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  // port 1 is read-first; port 1 wins if both ports write the same address
  always_ff @(posedge clk) begin
    if (we0) mem[addr0] <= data0;
    if (we1) mem[addr1] <= data1;
    q1 <= mem[addr1];
  end

endmodule

// File: rtl/jtkiwi_objbuf_bank.sv
// rtl/jtkiwi_objbuf_bank.sv - one line-buffer bank: port A draws, port B reads then erases
module jtkiwi_objbuf_bank #(
  parameter int AW = 9,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic [AW-1:0] b_addr,
  input  logic          b_we,
  output logic [DW-1:0] b_q
);

  // port B only ever writes zero (clear and erase)
  jtframe_dual_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .data0 (a_data),
    .addr0 (a_addr),
    .we0   (a_we),
    .data1 ({DW{1'b0}}),
    .addr1 (b_addr),
    .we1   (b_we),
    .q1    (b_q)
  );

endmodule

// File: rtl/jtkiwi_objbuf.sv
// rtl/jtkiwi_objbuf.sv - double-buffered sprite line buffer; JTKIWI_OBJBUF_FLIP_EN adds the flip input
module jtkiwi_objbuf
  import jtkiwi_objbuf_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = OBJ_PAL_LSB + OBJ_PAL_W
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          pxl_cen,
`ifdef JTKIWI_OBJBUF_FLIP_EN
  input  logic          flip,
`endif
  input  logic          HS,
  input  logic          buf_we,
  input  logic [AW-1:0] buf_addr,
  input  logic [DW-1:0] buf_data,
  input  logic [AW-1:0] hdump,
  output logic [DW-1:0] obj_pxl,
  output logic          busy
);

  objbuf_state_t st;
  logic          bank, hs_l, er_flag, er_bank;
  logic [AW-1:0] cnt, er_addr, rd_addr;
  logic [DW-1:0] rd_hold;
  logic          hs_edge, draw_we;

  logic          a_we   [2];
  logic [AW-1:0] a_addr [2];
  logic [DW-1:0] a_data [2];
  logic          b_we   [2];
  logic [AW-1:0] b_addr [2];
  logic [DW-1:0] b_q    [2];

  assign hs_edge = HS & ~hs_l;
  assign draw_we = buf_we & is_opaque(buf_data[OBJ_COL_LSB +: OBJ_COL_W]);

`ifdef JTKIWI_OBJBUF_FLIP_EN
  assign rd_addr = flip ? ~hdump : hdump;
`else
  assign rd_addr = hdump;
`endif

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      a_we[i]   = 1'b0;
      a_addr[i] = buf_addr;
      a_data[i] = buf_data;
      b_we[i]   = 1'b0;
      b_addr[i] = rd_addr;
      if (st == CLEAR) begin
        a_we[i]   = 1'b1;
        a_addr[i] = cnt;
        a_data[i] = '0;
        b_we[i]   = 1'b1;
        b_addr[i] = cnt;
      end else begin
        a_we[i] = draw_we && (bank == 1'(i));
        // erase uses the bank latched at read time, which may now be the draw bank
        if (er_flag && (er_bank == 1'(i))) begin
          b_we[i]   = 1'b1;
          b_addr[i] = er_addr;
        end
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    jtkiwi_objbuf_bank #(.AW(AW), .DW(DW)) u_bank (
      .clk    (clk),
      .a_we   (a_we[g]),
      .a_addr (a_addr[g]),
      .a_data (a_data[g]),
      .b_addr (b_addr[g]),
      .b_we   (b_we[g]),
      .b_q    (b_q[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= CLEAR;
      busy    <= 1'b1;
      bank    <= 1'b0;
      hs_l    <= 1'b0;
      er_flag <= 1'b0;
      er_bank <= 1'b0;
      er_addr <= '0;
      cnt     <= '0;
      rd_hold <= '0;
      obj_pxl <= '0;
    end else begin
      hs_l <= HS;
      case (st)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            st   <= RUN;
            busy <= 1'b0;
          end
        end
        RUN: begin
          if (hs_edge) bank <= ~bank;
          er_flag <= pxl_cen;
          if (pxl_cen) begin
            er_addr <= rd_addr;
            er_bank <= ~bank;
            obj_pxl <= rd_hold;
          end
          // read data is valid during the erase cycle; hold it for the next pixel
          if (er_flag) rd_hold <= b_q[er_bank];
        end
        default: st <= CLEAR;
      endcase
    end
  end

endmodule
